// File: rtl/arb8_pkg.sv
// Shared types, constants and helpers for the eight-requester arbitration scheduler.
package arb8_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    // Rotate an 8-bit vector right by s positions: bit j of the result is v[(j+s) mod 8].
    function automatic logic [N_REQ-1:0] rot_right8(
        input logic [N_REQ-1:0] v,
        input logic [IDX_W-1:0] s
    );
        logic [2*N_REQ-1:0] dbl_s;
        dbl_s = {v, v} >> s;
        return dbl_s[N_REQ-1:0];
    endfunction

endpackage

// File: rtl/pri_enc8.sv
// Combinational 8-to-3 priority encoder: reports the highest set index and whether any bit is set.
module pri_enc8
    import arb8_pkg::*;
(
    input  logic [N_REQ-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Later (higher) indices overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        idx = {IDX_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            idx = vec[i] ? IDX_W'(i) : idx;
        end
    end

    assign any = |vec;

endmodule

// File: rtl/arb8_sched.sv
// Eight-requester scheduler: fixed-priority or round-robin arbitration with a bounded hold time.
module arb8_sched
    import arb8_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             rr_en,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [IDX_W-1:0] last_r;
    logic [IDX_W-1:0] last_nxt_s;
    logic [7:0]       hold_cnt_r;
    logic [7:0]       hold_nxt_s;
    logic             mode_r;
    logic             mode_nxt_s;
    logic [N_REQ-1:0] gnt_nxt_s;
    logic [IDX_W-1:0] idx_nxt_s;
    logic             valid_nxt_s;
    logic             timeout_nxt_s;

    logic [IDX_W-1:0] rot_amt_s;
    logic [N_REQ-1:0] enc_in_s;
    logic [IDX_W-1:0] enc_idx_s;
    logic             enc_any_s;
    logic [IDX_W-1:0] win_idx_s;
    logic             owner_req_s;
    logic             at_max_s;

    // A zero rotation makes round-robin degenerate to fixed priority, so one encoder serves both.
    assign rot_amt_s   = rr_en ? last_r : 3'd0;
    assign enc_in_s    = rot_right8(req, rot_amt_s);
    assign win_idx_s   = enc_idx_s + rot_amt_s;
    assign owner_req_s = req[gnt_idx];
    assign at_max_s    = (hold_cnt_r == MAX_HOLD_C);

    pri_enc8 u_enc (
        .vec (enc_in_s),
        .idx (enc_idx_s),
        .any (enc_any_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decision: arbitrate from IDLE, leave GRANT on release or hold expiry.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (enc_any_s) begin
                    state_nxt_s = GRANT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GRANT: begin
                if (!owner_req_s || at_max_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = GRANT;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Next values of the registered outputs, hold counter, last owner and latched mode.
    always_comb begin
        gnt_nxt_s     = gnt;
        idx_nxt_s     = gnt_idx;
        valid_nxt_s   = gnt_valid;
        timeout_nxt_s = 1'b0;
        last_nxt_s    = last_r;
        hold_nxt_s    = hold_cnt_r;
        mode_nxt_s    = mode_r;
        case (state_r)
            IDLE: begin
                if (enc_any_s) begin
                    gnt_nxt_s   = 8'b0000_0001 << win_idx_s;
                    idx_nxt_s   = win_idx_s;
                    valid_nxt_s = 1'b1;
                    hold_nxt_s  = 8'd1;
                    mode_nxt_s  = rr_en;
                end else begin
                    gnt_nxt_s   = 8'b0000_0000;
                    idx_nxt_s   = 3'd0;
                    valid_nxt_s = 1'b0;
                    hold_nxt_s  = 8'd0;
                end
            end
            GRANT: begin
                // Release outranks expiry, so a simultaneous drop never pulses timeout.
                if (!owner_req_s) begin
                    gnt_nxt_s   = 8'b0000_0000;
                    idx_nxt_s   = 3'd0;
                    valid_nxt_s = 1'b0;
                    hold_nxt_s  = 8'd0;
                    if (mode_r) begin
                        last_nxt_s = gnt_idx;
                    end else begin
                        last_nxt_s = last_r;
                    end
                end else if (at_max_s) begin
                    gnt_nxt_s     = 8'b0000_0000;
                    idx_nxt_s     = 3'd0;
                    valid_nxt_s   = 1'b0;
                    hold_nxt_s    = 8'd0;
                    timeout_nxt_s = 1'b1;
                    last_nxt_s    = gnt_idx;
                end else if (hold_cnt_r < MAX_HOLD_C) begin
                    hold_nxt_s = hold_cnt_r + 8'd1;
                end else begin
                    hold_nxt_s = hold_cnt_r;
                end
            end
            default: begin
                gnt_nxt_s   = 8'b0000_0000;
                idx_nxt_s   = 3'd0;
                valid_nxt_s = 1'b0;
                hold_nxt_s  = 8'd0;
            end
        endcase
    end

    // Output and bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt        <= 8'b0000_0000;
            gnt_idx    <= 3'd0;
            gnt_valid  <= 1'b0;
            timeout    <= 1'b0;
            last_r     <= 3'd0;
            hold_cnt_r <= 8'd0;
            mode_r     <= 1'b0;
        end else begin
            gnt        <= gnt_nxt_s;
            gnt_idx    <= idx_nxt_s;
            gnt_valid  <= valid_nxt_s;
            timeout    <= timeout_nxt_s;
            last_r     <= last_nxt_s;
            hold_cnt_r <= hold_nxt_s;
            mode_r     <= mode_nxt_s;
        end
    end

endmodule

// File: doc/arb8_sched.md
# arb8_sched

Eight-requester arbitration scheduler that shares one downstream resource among requesters 0–7. It resolves contention through an 8-to-3 priority-encode stage, in either fixed priority (index 7 highest) or rotating round-robin. It holds each grant until the owner releases it or a hold limit expires. It sits between requester logic and the shared resource, and drives a one-hot grant, the encoded owner index and a valid flag.

## Interface
- MAX_HOLD, default 16: maximum consecutive cycles one grant may be held; legal range 1–255.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request vector; req[i] high means requester i wants the resource.
- rr_en  input  1  1 selects round-robin, 0 selects fixed priority; sampled only in IDLE.
- gnt  output  8  one-hot grant, registered.
- gnt_idx  output  3  binary index of the owner, registered; 0 when gnt_valid is 0.
- gnt_valid  output  1  high while any grant is active, registered.
- timeout  output  1  one-cycle pulse on the cycle after a grant is revoked by MAX_HOLD.

## Operation
- The clock is clk; reset is synchronous and active-high on rst. Reset sets gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, state=IDLE, last=0 and hold_cnt=0.
- The FSM has two states, IDLE and GRANT.
- In IDLE with req=0: stay in IDLE; all outputs stay 0.
- In IDLE with req≠0: choose winner w and go to GRANT. Register gnt=1<<w, gnt_idx=w, gnt_valid=1, hold_cnt=1, and latch mode=rr_en.
- Fixed-priority winner: the highest set index of req, which is the encoder function.
- Round-robin winner: search order last-1, last-2, …, 0, 7, …, last, wrapping modulo 8; the first set bit wins.
  - Implement by rotating req right by last, encoding, then adding last back modulo 8 (3-bit wrap).
  - With last=0 the order is 7…0, identical to fixed priority.
- In GRANT with req[gnt_idx]=0 (release): go to IDLE and clear gnt, gnt_idx and gnt_valid. last=gnt_idx is updated only when the latched mode is round-robin.
- In GRANT with hold_cnt==MAX_HOLD and req[gnt_idx] still 1: revoke the grant the same way as a release, set timeout=1 for the next cycle, and set last=gnt_idx in both modes.
- Otherwise in GRANT: hold the grant and increment hold_cnt, which saturates at MAX_HOLD.
- Requests from other requesters during GRANT are ignored; they do not preempt the owner.
- Release and timeout in the same cycle: treated as a release, so timeout stays 0.
- rr_en changes while in GRANT take effect at the next arbitration.

## Timing
- Request-to-grant latency is 1 cycle: req sampled high at edge N gives gnt valid after edge N.
- Release-to-deassert latency is 1 cycle.
- There is at least one IDLE cycle between consecutive grants, even for back-to-back requesters.
- Maximum continuous ownership is MAX_HOLD cycles.
- rst asserted mid-grant clears everything at the next edge; the first arbitration after reset uses last=0.
- gnt, gnt_idx and gnt_valid change only on clk edges and are glitch-free.

## Structure
- Package arb8_pkg:
  - state_t enum {IDLE, GRANT}
  - N_REQ=8 and IDX_W=3 constants
  - function rot_right8
- Sub-module pri_enc8: a combinational 8-to-3 encoder that outputs the highest set index and an any-set flag. It is instantiated once.
- Top level arb8_sched holds the FSM, the hold counter, the last register and the rotation/unrotation logic around pri_enc8.

## Test plan
- Reset and idle: hold rst for 2 cycles, then req=0 for 5 cycles -> gnt=0, gnt_idx=0, gnt_valid=0 and timeout=0 throughout.
- Fixed priority: rr_en=0, req=8'b0010_1001 -> after 1 cycle gnt=8'b0010_0000, gnt_idx=5. Drop req[5] -> 1 cycle later gnt=0; the next grant goes to 3.
- Round-robin rotation: rr_en=1, req=8'hFF held, each owner releases after 2 cycles -> grant order 7,6,5,4,3,2,1,0,7, with one idle cycle between grants.
- Timeout: MAX_HOLD=4, req=8'b0000_0100 held -> gnt_idx=2 for exactly 4 cycles. The timeout pulse is high on the following cycle. A re-grant to 2 occurs one cycle after the IDLE cycle.
- No preemption: the owner is index 1; assert req[7] mid-grant -> gnt stays 8'b0000_0010 until req[1] drops, then gnt_idx=7.
- Reset mid-grant: assert rst while gnt_idx=6 -> all outputs 0 at the next edge. After reset, rr_en=1 with req=8'b1100_0000 grants 7.
